mem_fifo_ctrl: RTL and testbench



---
 rtl/mem_fifo_ctrl_pkg.sv | 16 +
 rtl/mem_fifo_ptr.sv | 25 ++
 rtl/mem_fifo_ctrl.sv | 75 +++++++
 tb/tb_mem_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fifo_ctrl_pkg.sv
// rtl/mem_fifo_ctrl_pkg.sv - shared widths and wrap-around pointer increment for the FIFO controller
package mem_fifo_ctrl_pkg;

    localparam int FIFO_ADDR_SIZE = 4;
    localparam int FIFO_COUNT_W   = FIFO_ADDR_SIZE + 1;

    function automatic int count_width(input int addr_size);
        return addr_size + 1;
    endfunction

    // Wraps at depth-1 rather than at the address-space size, so non-power-of-two depths work.
    function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/mem_fifo_ptr.sv
// rtl/mem_fifo_ptr.sv - one wrap-around FIFO pointer with enable and synchronous clear
module mem_fifo_ptr
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    output logic [ADDR_SIZE-1:0] ptr
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ADDR_SIZE'(ptr_next(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - turns a 2R/1W register file into a DEPTH-entry valid/ready FIFO
module mem_fifo_ctrl
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int BYTE_SIZE = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BYTE_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BYTE_SIZE-1:0] out_data,
    output logic [ADDR_SIZE:0]   level,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_waddr,
    output logic [BYTE_SIZE-1:0] mem_wdata,
    output logic [ADDR_SIZE-1:0] mem_raddr,
    input  logic [BYTE_SIZE-1:0] mem_rdata
);

    localparam int CW = count_width(ADDR_SIZE);

    logic [ADDR_SIZE-1:0] wptr;
    logic [ADDR_SIZE-1:0] rptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;

    // Ready depends only on registered count, so a pop from full frees the slot next cycle.
    assign in_ready  = !flush && (count != CW'(DEPTH));
    assign out_valid = !flush && (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign mem_wen   = push;
    assign mem_waddr = wptr;
    assign mem_wdata = in_data;
    assign mem_raddr = rptr;
    assign out_data  = mem_rdata;
    assign level     = count;

    mem_fifo_ptr #(.ADDR_SIZE(ADDR_SIZE), .DEPTH(DEPTH)) u_wptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .en    (push),
        .ptr   (wptr)
    );

    mem_fifo_ptr #(.ADDR_SIZE(ADDR_SIZE), .DEPTH(DEPTH)) u_rptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .en    (pop),
        .ptr   (rptr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - scoreboard bench for mem_fifo_ctrl at DEPTH=4 and DEPTH=5
module tb_mem_fifo_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic       d4_flush = 1'b0, d4_in_valid = 1'b0, d4_out_ready = 1'b0;
    logic [7:0] d4_in_data = '0;
    logic       d4_in_ready, d4_out_valid, d4_mem_wen;
    logic [7:0] d4_out_data, d4_mem_wdata, d4_mem_rdata;
    logic [4:0] d4_level;
    logic [3:0] d4_mem_waddr, d4_mem_raddr;
    logic [7:0] mem4 [16];

    logic       d5_flush = 1'b0, d5_in_valid = 1'b0, d5_out_ready = 1'b0;
    logic [7:0] d5_in_data = '0;
    logic       d5_in_ready, d5_out_valid, d5_mem_wen;
    logic [7:0] d5_out_data, d5_mem_wdata, d5_mem_rdata;
    logic [4:0] d5_level;
    logic [3:0] d5_mem_waddr, d5_mem_raddr;
    logic [7:0] mem5 [16];

    mem_fifo_ctrl #(.ADDR_SIZE(4), .BYTE_SIZE(8), .DEPTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .flush(d4_flush),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
        .level(d4_level), .mem_wen(d4_mem_wen), .mem_waddr(d4_mem_waddr),
        .mem_wdata(d4_mem_wdata), .mem_raddr(d4_mem_raddr), .mem_rdata(d4_mem_rdata)
    );

    mem_fifo_ctrl #(.ADDR_SIZE(4), .BYTE_SIZE(8), .DEPTH(5)) u_dut5 (
        .clock(clock), .reset(reset), .flush(d5_flush),
        .in_valid(d5_in_valid), .in_ready(d5_in_ready), .in_data(d5_in_data),
        .out_valid(d5_out_valid), .out_ready(d5_out_ready), .out_data(d5_out_data),
        .level(d5_level), .mem_wen(d5_mem_wen), .mem_waddr(d5_mem_waddr),
        .mem_wdata(d5_mem_wdata), .mem_raddr(d5_mem_raddr), .mem_rdata(d5_mem_rdata)
    );

    always @(posedge clock) if (d4_mem_wen) mem4[d4_mem_waddr] <= d4_mem_wdata;
    always @(posedge clock) if (d5_mem_wen) mem5[d5_mem_waddr] <= d5_mem_wdata;
    assign d4_mem_rdata = mem4[d4_mem_raddr];
    assign d5_mem_rdata = mem5[d5_mem_raddr];

    logic [7:0] sb4[$];
    logic [7:0] sb5[$];
    int         wq5[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic inv(input string name, input int cnt, input int w, input int r, input int depth);
        int diff;
        diff = (w - r + depth) % depth;
        tests++;
        if (!(cnt <= depth && (cnt == diff || (cnt == depth && w == r)))) begin
            fails++;
            $display("FAIL %s: count %0d wptr %0d rptr %0d depth %0d", name, cnt, w, r, depth);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (d4_out_valid && d4_out_ready) begin
                if (sb4.size() == 0) chk("d4_unexpected_pop", 1, 0);
                else chk("d4_out_data", int'(d4_out_data), int'(sb4.pop_front()));
            end
            if (d5_out_valid && d5_out_ready) begin
                if (sb5.size() == 0) chk("d5_unexpected_pop", 1, 0);
                else chk("d5_out_data", int'(d5_out_data), int'(sb5.pop_front()));
            end
            if (d5_mem_wen) begin
                if (wq5.size() == 0) chk("d5_unexpected_write", 1, 0);
                else chk("d5_mem_waddr", int'(d5_mem_waddr), wq5.pop_front());
            end
            inv("d4_invariant", int'(u_dut4.count), int'(u_dut4.u_wptr.ptr), int'(u_dut4.u_rptr.ptr), 4);
            inv("d5_invariant", int'(u_dut5.count), int'(u_dut5.u_wptr.ptr), int'(u_dut5.u_rptr.ptr), 5);
        end
    end

    initial begin
        int waddr_tbl [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};

        #12 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("rst_in_ready", d4_in_ready, 1);
            chk("rst_out_valid", d4_out_valid, 0);
            chk("rst_level", d4_level, 0);
            chk("rst_mem_wen", d4_mem_wen, 0);
        end
        chk("rst_waddr", d4_mem_waddr, 0);
        chk("rst_raddr", d4_mem_raddr, 0);
        cyc();

        for (int i = 1; i <= 4; i++) begin
            d4_in_valid = 1'b1; d4_in_data = 8'(i); d4_out_ready = 1'b0;
            @(negedge clock);
            chk("fill_in_ready", d4_in_ready, 1);
            chk("fill_waddr", d4_mem_waddr, i - 1);
            sb4.push_back(8'(i));
            cyc();
            chk("fill_level", d4_level, i);
        end
        d4_in_data = 8'd99;
        @(negedge clock);
        chk("full_in_ready", d4_in_ready, 0);
        chk("full_no_write", d4_mem_wen, 0);
        cyc();
        chk("full_level_held", d4_level, 4);
        d4_out_ready = 1'b1;
        @(negedge clock);
        chk("full_pop_no_ready", d4_in_ready, 0);
        d4_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("drain_out_valid", d4_out_valid, 0);
        chk("drain_level", d4_level, 0);

        d4_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d4_in_valid = 1'b1; d4_in_data = 8'(20 + i);
            @(negedge clock);
            sb4.push_back(8'(20 + i));
            cyc();
        end
        chk("pp_pre_level", d4_level, 2);
        for (int k = 0; k < 10; k++) begin
            d4_in_valid = 1'b1; d4_in_data = 8'(5 + k); d4_out_ready = 1'b1;
            @(negedge clock);
            chk("pp_mem_wen", d4_mem_wen, 1);
            sb4.push_back(8'(5 + k));
            cyc();
            chk("pp_level", d4_level, 2);
        end
        d4_in_valid = 1'b0;
        cyc(); cyc();
        chk("pp_drained_level", d4_level, 0);
        d4_out_ready = 1'b0;

        for (int i = 0; i < 12; i++) wq5.push_back(waddr_tbl[i]);
        for (int i = 0; i < 12; i++) begin
            d5_in_valid = 1'b1; d5_in_data = 8'(30 + i); d5_out_ready = 1'b1;
            @(negedge clock);
            chk("d5_in_ready", d5_in_ready, 1);
            sb5.push_back(8'(30 + i));
            cyc();
        end
        d5_in_valid = 1'b0;
        cyc(); cyc();
        chk("d5_level_end", d5_level, 0);
        chk("d5_waddr_all_seen", wq5.size(), 0);
        d5_out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            d4_in_valid = 1'b1; d4_in_data = 8'(40 + i);
            @(negedge clock);
            sb4.push_back(8'(40 + i));
            cyc();
        end
        chk("flush_pre_level", d4_level, 3);
        d4_in_data = 8'd50; d4_out_ready = 1'b1; d4_flush = 1'b1;
        @(negedge clock);
        chk("flush_mem_wen", d4_mem_wen, 0);
        chk("flush_out_valid", d4_out_valid, 0);
        sb4.delete();
        cyc();
        d4_flush = 1'b0; d4_in_valid = 1'b0; d4_out_ready = 1'b0;
        #1;
        chk("flush_level", d4_level, 0);
        chk("flush_post_out_valid", d4_out_valid, 0);
        d4_in_valid = 1'b1; d4_in_data = 8'd60;
        @(negedge clock);
        chk("flush_next_waddr", d4_mem_waddr, 0);
        sb4.push_back(8'd60);
        cyc();
        d4_in_valid = 1'b0; d4_out_ready = 1'b1;
        @(negedge clock);
        chk("flush_next_raddr", d4_mem_raddr, 0);
        cyc();
        d4_out_ready = 1'b0;

        for (int i = 0; i < 2; i++) begin
            d4_in_valid = 1'b1; d4_in_data = 8'(70 + i);
            @(negedge clock);
            sb4.push_back(8'(70 + i));
            cyc();
        end
        d4_in_valid = 1'b0;
        chk("arst_pre_level", d4_level, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_level", d4_level, 0);
        chk("arst_out_valid", d4_out_valid, 0);
        sb4.delete();
        #3 reset = 1'b0;
        cyc();
        chk("arst_in_ready", d4_in_ready, 1);
        chk("arst_waddr", d4_mem_waddr, 0);
        d4_in_valid = 1'b1; d4_in_data = 8'd80;
        @(negedge clock);
        sb4.push_back(8'd80);
        cyc();
        d4_in_valid = 1'b0; d4_out_ready = 1'b1;
        cyc();
        chk("arst_readback_level", d4_level, 0);
        d4_out_ready = 1'b0;
        cyc();

        chk("d4_scoreboard_empty", sb4.size(), 0);
        chk("d5_scoreboard_empty", sb5.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
